// File: rtl/aes_round_ctrl_pkg.sv
// Shared definitions for the AES round controller.
//   aes_round_state_t : controller state encoding
//   AES_NB_WORDS      : 32-bit words per AES state block
//   AES_RCON_INIT     : round constant used in the first round
//   AES_LAST_WORD     : word_idx value of the final word of a block
package aes_package;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INIT_ARK,
    ST_ROUND,
    ST_UNLOAD,
    ST_DONE
  } aes_round_state_t;

  localparam int         AES_NB_WORDS  = 4;
  localparam logic [7:0] AES_RCON_INIT = 8'h01;
  localparam logic [1:0] AES_LAST_WORD = 2'(AES_NB_WORDS - 1);

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant successor: multiplication by x in GF(2^8) (xtime).
//   rcon_i : current round constant
//   rcon_o : round constant for the following round
module aes_rcon_gen (
  input  logic [7:0] rcon_i,
  output logic [7:0] rcon_o
);

  // A carry out of bit 7 is reduced by the AES polynomial x^8+x^4+x^3+x+1.
  assign rcon_o = {rcon_i[6:0], 1'b0} ^ (rcon_i[7] ? 8'h1B : 8'h00);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES block-operation sequencer. Loads four state words, issues the initial
// AddRoundKey, NR round strobes with key-expansion steps and round constants,
// then unloads four words. The state words and keys live in an external
// datapath; this block only produces its control strobes.
//   clk, clear               : clock, synchronous active-high reset
//   start                    : begin a block (honoured only when idle)
//   data_in_valid/ready      : input word handshake
//   data_out_valid/ready     : output word handshake
//   word_idx                 : word index for the datapath load/unload mux
//   dp_load                  : write the input word at word_idx
//   dp_init_ark              : initial AddRoundKey
//   dp_round_en              : apply one round
//   dp_last_round            : final round, skip MixColumns
//   key_expand_en            : advance the round-key register
//   round_idx, rcon          : current round number and round constant
//   busy, done               : not idle / one-cycle completion pulse
module aes_round_ctrl
  import aes_package::*;
#(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic [1:0] word_idx,
  output logic       dp_load,
  output logic       dp_init_ark,
  output logic       dp_round_en,
  output logic       dp_last_round,
  output logic       key_expand_en,
  output logic [3:0] round_idx,
  output logic [7:0] rcon,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] NR_IDX = 4'(NR);

  aes_round_state_t state_q;
  logic [1:0] word_idx_q;
  logic [3:0] round_idx_q;
  logic [7:0] rcon_q;
  logic [7:0] rcon_d;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       init_ark_q;
  logic       round_en_q;
  logic       last_round_q;
  logic       key_en_q;
  logic       busy_q;
  logic       done_q;

  aes_rcon_gen u_rcon_gen (
    .rcon_i (rcon_q),
    .rcon_o (rcon_d)
  );

  // Each strobe is registered alongside the transition into the state that
  // owns it, so every output except dp_load comes straight from a flop.
  // NOTE: every register here is written with <= so all of them update
  // together from pre-edge values; a blocking = would let later lines see
  // already-updated state within the same edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      // NOTE: reset is sampled on the clock edge, so it sits inside the
      // clocked block rather than in the sensitivity list.
      state_q      <= ST_IDLE;
      word_idx_q   <= '0;
      round_idx_q  <= '0;
      rcon_q       <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      init_ark_q   <= 1'b0;
      round_en_q   <= 1'b0;
      last_round_q <= 1'b0;
      key_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_LOAD;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (data_in_valid) begin
            // Two-bit index wraps to 0 after the last word.
            word_idx_q <= word_idx_q + 2'd1;
            if (word_idx_q == AES_LAST_WORD) begin
              state_q    <= ST_INIT_ARK;
              in_ready_q <= 1'b0;
              init_ark_q <= 1'b1;
            end
          end
        end

        ST_INIT_ARK: begin
          state_q      <= ST_ROUND;
          init_ark_q   <= 1'b0;
          round_en_q   <= 1'b1;
          key_en_q     <= 1'b1;
          round_idx_q  <= 4'd1;
          rcon_q       <= AES_RCON_INIT;
          last_round_q <= (NR_IDX == 4'd1);
        end

        ST_ROUND: begin
          round_idx_q <= round_idx_q + 4'd1;
          rcon_q      <= rcon_d;
          if (round_idx_q == NR_IDX) begin
            state_q      <= ST_UNLOAD;
            round_en_q   <= 1'b0;
            key_en_q     <= 1'b0;
            last_round_q <= 1'b0;
            out_valid_q  <= 1'b1;
          end else begin
            // Flag the final round one cycle ahead so it lines up with it.
            last_round_q <= (round_idx_q + 4'd1 == NR_IDX);
          end
        end

        ST_UNLOAD: begin
          if (data_out_ready) begin
            word_idx_q <= word_idx_q + 2'd1;
            if (word_idx_q == AES_LAST_WORD) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state_q     <= ST_IDLE;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          round_idx_q <= '0;
          rcon_q      <= '0;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // The load strobe must follow the same-cycle handshake, so it is the one
  // combinational output.
  assign dp_load        = in_ready_q & data_in_valid;
  assign data_in_ready  = in_ready_q;
  assign data_out_valid = out_valid_q;
  assign word_idx       = word_idx_q;
  assign dp_init_ark    = init_ark_q;
  assign dp_round_en    = round_en_q;
  assign dp_last_round  = last_round_q;
  assign key_expand_en  = key_en_q;
  assign round_idx      = round_idx_q;
  assign rcon           = rcon_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clear;

  // NR=10 instance
  logic       start, data_in_valid, data_out_ready;
  logic       data_in_ready, data_out_valid, dp_load, dp_init_ark;
  logic       dp_round_en, dp_last_round, key_expand_en, busy, done;
  logic [1:0] word_idx;
  logic [3:0] round_idx;
  logic [7:0] rcon;

  // NR=14 instance
  logic       start14, data_in_valid14, data_out_ready14;
  logic       data_in_ready14, data_out_valid14, dp_load14, dp_init_ark14;
  logic       dp_round_en14, dp_last_round14, key_expand_en14, busy14, done14;
  logic [1:0] word_idx14;
  logic [3:0] round_idx14;
  logic [7:0] rcon14;

  aes_round_ctrl #(.NR(10)) u_dut10 (
    .clk(clk), .clear(clear), .start(start),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .word_idx(word_idx), .dp_load(dp_load), .dp_init_ark(dp_init_ark),
    .dp_round_en(dp_round_en), .dp_last_round(dp_last_round),
    .key_expand_en(key_expand_en), .round_idx(round_idx), .rcon(rcon),
    .busy(busy), .done(done)
  );

  aes_round_ctrl #(.NR(14)) u_dut14 (
    .clk(clk), .clear(clear), .start(start14),
    .data_in_valid(data_in_valid14), .data_in_ready(data_in_ready14),
    .data_out_valid(data_out_valid14), .data_out_ready(data_out_ready14),
    .word_idx(word_idx14), .dp_load(dp_load14), .dp_init_ark(dp_init_ark14),
    .dp_round_en(dp_round_en14), .dp_last_round(dp_last_round14),
    .key_expand_en(key_expand_en14), .round_idx(round_idx14), .rcon(rcon14),
    .busy(busy14), .done(done14)
  );

  logic [22:0] outs10, outs14;
  assign outs10 = {data_in_ready, data_out_valid, word_idx, dp_load, dp_init_ark,
                   dp_round_en, dp_last_round, key_expand_en, round_idx, rcon,
                   busy, done};
  assign outs14 = {data_in_ready14, data_out_valid14, word_idx14, dp_load14,
                   dp_init_ark14, dp_round_en14, dp_last_round14, key_expand_en14,
                   round_idx14, rcon14, busy14, done14};

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  // AES round constants, rounds 1..14
  logic [7:0] rcon_tab [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D};

  typedef struct packed {
    logic [3:0] ridx;
    logic [7:0] rc;
    logic       last;
  } round_exp_t;

  round_exp_t exp_round_q[$];
  round_exp_t exp_round14_q[$];
  logic [1:0] exp_load_q[$];
  logic [1:0] exp_unload_q[$];

  // Scoreboard monitors: pop an expectation whenever the DUT produces an event.
  always @(negedge clk) begin
    round_exp_t e;
    logic [1:0] w;
    if (done === 1'b1) done_cnt++;
    if (dp_load === 1'b1) begin
      total++;
      if (exp_load_q.size() == 0) begin
        bad++; $display("FAIL load_word: unexpected dp_load word_idx=%0d", word_idx);
      end else begin
        w = exp_load_q.pop_front();
        if (word_idx !== w) begin
          bad++; $display("FAIL load_word: got word_idx=%0d want %0d", word_idx, w);
        end
      end
    end
    if (dp_round_en === 1'b1) begin
      total++;
      if (exp_round_q.size() == 0) begin
        bad++; $display("FAIL round10: unexpected round cycle round_idx=%0d", round_idx);
      end else begin
        e = exp_round_q.pop_front();
        if (round_idx !== e.ridx || rcon !== e.rc || dp_last_round !== e.last ||
            key_expand_en !== 1'b1) begin
          bad++;
          $display("FAIL round10: got idx=%0d rcon=%h last=%b kexp=%b want idx=%0d rcon=%h last=%b kexp=1",
                   round_idx, rcon, dp_last_round, key_expand_en, e.ridx, e.rc, e.last);
        end
      end
    end
    if (data_out_valid === 1'b1 && data_out_ready === 1'b1) begin
      total++;
      if (exp_unload_q.size() == 0) begin
        bad++; $display("FAIL unload_word: unexpected handshake word_idx=%0d", word_idx);
      end else begin
        w = exp_unload_q.pop_front();
        if (word_idx !== w) begin
          bad++; $display("FAIL unload_word: got word_idx=%0d want %0d", word_idx, w);
        end
      end
    end
  end

  always @(negedge clk) begin
    round_exp_t e;
    if (dp_round_en14 === 1'b1) begin
      total++;
      if (exp_round14_q.size() == 0) begin
        bad++; $display("FAIL round14: unexpected round cycle round_idx=%0d", round_idx14);
      end else begin
        e = exp_round14_q.pop_front();
        if (round_idx14 !== e.ridx || rcon14 !== e.rc || dp_last_round14 !== e.last) begin
          bad++;
          $display("FAIL round14: got idx=%0d rcon=%h last=%b want idx=%0d rcon=%h last=%b",
                   round_idx14, rcon14, dp_last_round14, e.ridx, e.rc, e.last);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_block10();
    round_exp_t e;
    for (int w = 0; w < 4; w++) begin
      exp_load_q.push_back(2'(w));
      exp_unload_q.push_back(2'(w));
    end
    for (int r = 1; r <= 10; r++) begin
      e.ridx = 4'(r);
      e.rc   = rcon_tab[r-1];
      e.last = (r == 10);
      exp_round_q.push_back(e);
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_load_q.size() + exp_round_q.size() + exp_unload_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drained: left load=%0d round=%0d unload=%0d want 0/0/0", name,
               exp_load_q.size(), exp_round_q.size(), exp_unload_q.size());
    end
  endtask

  // Start a block on the NR=10 instance and feed four back-to-back words.
  task automatic start_and_load();
    start = 1'b1; tick(); start = 1'b0;
    data_in_valid = 1'b1; repeat (4) tick(); data_in_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output logic seen);
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (2) tick();
    total++;
    if (outs10 !== '0) begin bad++; $display("FAIL reset_outs10: got %h want 0", outs10); end
    total++;
    if (outs14 !== '0) begin bad++; $display("FAIL reset_outs14: got %h want 0", outs14); end
    // clear wins over a simultaneous start
    start = 1'b1; tick(); start = 1'b0; clear = 1'b0;
    total++;
    if (busy !== 1'b0 || data_in_ready !== 1'b0) begin
      bad++; $display("FAIL clear_priority: got busy=%b in_ready=%b want 0/0", busy, data_in_ready);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_hold: got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int rounds = 0;
    int first  = -1;
    push_block10();
    data_out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    total++;
    if (data_in_ready !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL load_entry: got in_ready=%b busy=%b want 1/1", data_in_ready, busy);
    end
    data_in_valid = 1'b1; repeat (4) tick(); data_in_valid = 1'b0;
    total++;
    if (dp_init_ark !== 1'b1 || dp_round_en !== 1'b0 || data_in_ready !== 1'b0) begin
      bad++; $display("FAIL init_ark: got ark=%b round_en=%b in_ready=%b want 1/0/0",
                      dp_init_ark, dp_round_en, data_in_ready);
    end
    for (int k = 1; k <= 40 && first < 0; k++) begin
      tick();
      if (dp_init_ark === 1'b1) begin bad++; total++; $display("FAIL init_ark_len: got extra cycle want 1 cycle"); end
      if (dp_round_en === 1'b1) rounds++;
      if (data_out_valid === 1'b1) first = k;
    end
    total++;
    if (rounds != 10) begin bad++; $display("FAIL round_count: got %0d want 10", rounds); end
    total++;
    if (first != 11) begin bad++; $display("FAIL out_latency: got %0d want 11", first); end
    repeat (3) tick();
    total++;
    if (data_out_valid !== 1'b1 || word_idx !== 2'd3) begin
      bad++; $display("FAIL unload_last: got valid=%b idx=%0d want 1/3", data_out_valid, word_idx);
    end
    tick();
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || data_out_valid !== 1'b0) begin
      bad++; $display("FAIL done_pulse: got done=%b busy=%b valid=%b want 1/1/0", done, busy, data_out_valid);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL done_end: got done=%b busy=%b want 0/0", done, busy);
    end
    data_out_ready = 1'b0;
    check_drained("back_to_back");
  endtask

  task automatic test_rcon_seq();
    int lasts = 0;
    int kexp  = 0;
    logic [3:0] last_idx = '0;
    logic seen = 1'b0;
    push_block10();
    data_out_ready = 1'b1;
    start_and_load();
    for (int k = 0; k < 40 && !seen; k++) begin
      if (dp_last_round === 1'b1) begin lasts++; last_idx = round_idx; end
      if (key_expand_en === 1'b1) kexp++;
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL rcon_done: got no done want done"); end
    total++;
    if (lasts != 1 || last_idx !== 4'd10) begin
      bad++; $display("FAIL last_round: got pulses=%0d idx=%0d want 1/10", lasts, last_idx);
    end
    total++;
    if (kexp != 10) begin bad++; $display("FAIL key_expand: got %0d want 10", kexp); end
    data_out_ready = 1'b0;
    tick();
    check_drained("rcon_seq");
  endtask

  task automatic test_in_stall();
    logic [6:0] pat = 7'b1011001; // bit0 first: 1,0,0,1,1,0,1
    int loads = 0;
    logic seen;
    push_block10();
    data_out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      data_in_valid = pat[i];
      @(negedge clk);
      if (dp_load === 1'b1) loads++;
      tick();
    end
    data_in_valid = 1'b0;
    total++;
    if (loads != 4) begin bad++; $display("FAIL in_stall_loads: got %0d want 4", loads); end
    total++;
    if (dp_init_ark !== 1'b1) begin bad++; $display("FAIL in_stall_ark: got %b want 1", dp_init_ark); end
    data_out_ready = 1'b1;
    wait_done(40, seen);
    total++;
    if (!seen) begin bad++; $display("FAIL in_stall_done: got no done want done"); end
    data_out_ready = 1'b0;
    tick();
    check_drained("in_stall");
  endtask

  task automatic test_out_stall();
    logic found = 1'b0;
    int hs = 0;
    push_block10();
    data_out_ready = 1'b0;
    start_and_load();
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (data_out_valid === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL out_stall_valid: got no data_out_valid want valid"); end
    for (int c = 0; c < 5; c++) begin
      start = (c == 0); // start in UNLOAD must be ignored
      tick();
      start = 1'b0;
      total++;
      if (data_out_valid !== 1'b1 || word_idx !== 2'd0 || done !== 1'b0) begin
        bad++; $display("FAIL out_stall_hold: cycle %0d got valid=%b idx=%0d done=%b want 1/0/0",
                        c, data_out_valid, word_idx, done);
      end
    end
    data_out_ready = 1'b1;
    for (int k = 0; k < 20 && hs < 4; k++) begin
      @(negedge clk);
      if (data_out_valid === 1'b1) hs++;
      tick();
    end
    data_out_ready = 1'b0;
    total++;
    if (hs != 4) begin bad++; $display("FAIL out_stall_hs: got %0d want 4", hs); end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL out_stall_done: got %b want 1", done); end
    repeat (2) tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL out_stall_idle: got busy=%b done=%b want 0/0", busy, done);
    end
    check_drained("out_stall");
  endtask

  task automatic test_clear_mid();
    int done_before;
    logic found = 1'b0;
    logic seen;
    push_block10();
    data_out_ready = 1'b1;
    start_and_load();
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (dp_round_en === 1'b1 && round_idx === 4'd5) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL clear_reach_r5: got no round 5 want round 5"); end
    done_before = done_cnt;
    clear = 1'b1; tick(); clear = 1'b0;
    total++;
    if (outs10 !== '0) begin bad++; $display("FAIL clear_outs: got %h want 0", outs10); end
    exp_round_q.delete();
    exp_unload_q.delete();
    repeat (20) tick();
    total++;
    if (done_cnt != done_before || busy !== 1'b0) begin
      bad++; $display("FAIL clear_no_done: got done pulses=%0d busy=%b want 0/0",
                      done_cnt - done_before, busy);
    end
    // a fresh block after the abort
    push_block10();
    start_and_load();
    wait_done(40, seen);
    total++;
    if (!seen) begin bad++; $display("FAIL after_clear_done: got no done want done"); end
    data_out_ready = 1'b0;
    tick();
    check_drained("after_clear");
  endtask

  task automatic test_nr14();
    round_exp_t e;
    int rounds = 0;
    int first  = -1;
    logic seen = 1'b0;
    for (int r = 1; r <= 14; r++) begin
      e.ridx = 4'(r);
      e.rc   = rcon_tab[r-1];
      e.last = (r == 14);
      exp_round14_q.push_back(e);
    end
    data_out_ready14 = 1'b1;
    start14 = 1'b1; tick(); start14 = 1'b0;
    data_in_valid14 = 1'b1; repeat (4) tick(); data_in_valid14 = 1'b0;
    total++;
    if (dp_init_ark14 !== 1'b1) begin bad++; $display("FAIL nr14_ark: got %b want 1", dp_init_ark14); end
    for (int k = 1; k <= 40 && first < 0; k++) begin
      tick();
      if (dp_round_en14 === 1'b1) rounds++;
      if (data_out_valid14 === 1'b1) first = k;
    end
    total++;
    if (rounds != 14) begin bad++; $display("FAIL nr14_rounds: got %0d want 14", rounds); end
    total++;
    if (first != 15) begin bad++; $display("FAIL nr14_latency: got %0d want 15", first); end
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (done14 === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL nr14_done: got no done want done"); end
    data_out_ready14 = 1'b0;
    tick();
    total++;
    if (exp_round14_q.size() != 0) begin
      bad++; $display("FAIL nr14_drained: got %0d left want 0", exp_round14_q.size());
    end
  endtask

  initial begin
    clear = 1'b1;
    start = 1'b0; data_in_valid = 1'b0; data_out_ready = 1'b0;
    start14 = 1'b0; data_in_valid14 = 1'b0; data_out_ready14 = 1'b0;
    test_reset();
    test_back_to_back();
    test_rcon_seq();
    test_in_stall();
    test_out_stall();
    test_clear_mid();
    test_nr14();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, the number of AES rounds (legal values 10, 12, 14).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clear, input, 1 bit: the reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: begin one block operation; sampled only in IDLE.
REQ-005 SHALL have port data_in_valid, input, 1 bit: input word valid.
REQ-006 SHALL have port data_in_ready, output, 1 bit: the controller accepts an input word.
REQ-007 SHALL have port data_out_valid, output, 1 bit: output word valid.
REQ-008 SHALL have port data_out_ready, input, 1 bit: the consumer accepts an output word.
REQ-009 SHALL have port word_idx, output, 2 bits: state-word index for the datapath load/unload mux.
REQ-010 SHALL have port dp_load, output, 1 bit: the datapath writes the input word at word_idx.
REQ-011 SHALL have port dp_init_ark, output, 1 bit: initial AddRoundKey only.
REQ-012 SHALL have port dp_round_en, output, 1 bit: apply one full round.
REQ-013 SHALL have port dp_last_round, output, 1 bit: skip MixColumns this round.
REQ-014 SHALL have port key_expand_en, output, 1 bit: advance the round-key register.
REQ-015 SHALL have port round_idx, output, 4 bits: current round number (1..NR).
REQ-016 SHALL have port rcon, output, 8 bits: round constant for the key expansion.
REQ-017 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-018 SHALL have port done, output, 1 bit: one-cycle pulse when the block completes.

Function
REQ-019 SHALL implement states IDLE, LOAD, INIT_ARK, ROUND, UNLOAD, DONE.
REQ-020 SHALL move from IDLE to LOAD on start=1; start outside IDLE SHALL be ignored.
REQ-021 In LOAD, SHALL drive data_in_ready=1; a word is accepted when valid&&ready, asserting dp_load for that cycle and then incrementing word_idx.
REQ-022 SHALL leave LOAD for INIT_ARK on acceptance of the word with word_idx=3; word_idx SHALL then wrap to 0.
REQ-023 INIT_ARK SHALL last exactly 1 cycle with dp_init_ark=1; round_idx SHALL then be set to 1 and rcon to 0x01.
REQ-024 ROUND SHALL last exactly NR cycles with dp_round_en=1 and key_expand_en=1 on each cycle; round_idx and rcon SHALL be updated after each cycle.
REQ-025 The rcon update SHALL be an 8-bit xtime: rcon<<1 when bit7=0, otherwise (rcon<<1)^0x1B.
REQ-026 SHALL assert dp_last_round only in the ROUND cycle where round_idx==NR; the next state SHALL be UNLOAD.
REQ-027 In UNLOAD, SHALL drive data_out_valid=1; each data_out_valid&&data_out_ready SHALL increment word_idx.
REQ-028 While data_out_ready=0, data_out_valid and word_idx SHALL stay stable.
REQ-029 SHALL leave UNLOAD for DONE on the handshake of the word with word_idx=3; DONE SHALL last 1 cycle with done=1 and then return to IDLE.
REQ-030 Latency from the 4th input handshake to the first data_out_valid SHALL be NR+1 cycles.
REQ-031 data_in_ready SHALL be 0 outside LOAD, and data_out_valid SHALL be 0 outside UNLOAD.
REQ-032 All dp_* outputs and key_expand_en SHALL be 0 in any state not named for them.

Reset
REQ-033 clear=1 SHALL force IDLE on the next edge from any state, abandoning any partial load or unload without a done pulse.
REQ-034 Reset values SHALL be: all outputs 0, word_idx=0, round_idx=0, rcon=0x00.
REQ-035 clear SHALL have priority over start when both are high in the same cycle.

Structure
REQ-036 The state enum aes_round_state_t, AES_NB_WORDS=4 and AES_RCON_INIT=8'h01 SHALL live in aes_package.
REQ-037 The xtime round-constant update SHALL be a sub-module named aes_rcon_gen (8-bit combinational).
REQ-038 The controller SHALL contain no data path; state words and keys SHALL stay external.

Verification
REQ-039 Scenario 1: NR=10, start, 4 back-to-back input words -> dp_init_ark on the next cycle, then 10 dp_round_en cycles, first data_out_valid 11 cycles after the 4th handshake.
REQ-040 Scenario 2: NR=10 -> rcon sequence 01,02,04,08,10,20,40,80,1B,36; dp_last_round only at round_idx=10.
REQ-041 Scenario 3: data_in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 dp_load pulses with word_idx 0,1,2,3.
REQ-042 Scenario 4: data_out_ready held 0 for 5 cycles in UNLOAD -> word_idx=0 held and data_out_valid held; done exactly 1 cycle after the 4th output handshake.
REQ-043 Scenario 5: clear during ROUND at round_idx=5 -> IDLE with all outputs 0 next cycle and no done; a following start runs a full block correctly.
REQ-044 Scenario 6: NR=14 -> 14 round cycles, last rcon 0x36 reached at round 10 and continuing 6C,D8,AB,4D.
